alu_vec_gen: RTL
================

Name: alu_vec_gen

Overview:
Parametrised ALU stimulus generator; successor to the fixed 16-entry op/A/B sequencer. Emits {op, A, B} vectors over a valid/ready handshake in two modes: directed corner-value sweep over every opcode, or LFSR pseudo-random operands with a swept opcode for a programmable vector count. Sits between bench/board control and the ALU under test; the ALU result checker consumes the same handshake.

Parameters:
DATA_WIDTH  32  operand width A/B; 2..32
OP_WIDTH  4  opcode width
N_OPS  16  opcodes swept, 0..N_OPS-1; N_OPS <= 2**OP_WIDTH
SEED  32'h00000001  LFSR_A seed; 0 replaced by 1; LFSR_B seed = ~SEED (0 replaced by 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  start run; sampled only in IDLE
mode  in  1  0 = directed, 1 = random; captured on accepted start
len  in  16  random-mode vector count; captured on accepted start
ready  in  1  consumer accepts current vector
valid  out  1  A/B/op hold a vector
A  out  DATA_WIDTH  operand A
B  out  DATA_WIDTH  operand B
op  out  OP_WIDTH  opcode
last  out  1  current vector is final of run (qualified by valid)
busy  out  1  run in progress
done  out  1  one-cycle pulse after final vector accepted

Behaviour:
- Reset (async assert, any state): state IDLE; valid, last, done, busy = 0; A, B, op = 0; counters 0; LFSR_A = SEED, LFSR_B = ~SEED (zero-fixed). Reset mid-run abandons run, no done.
- FSM: IDLE -> RUN on start=1 (captures mode, len). RUN -> DONE on accept of vector with last=1. DONE -> IDLE unconditionally next cycle (done=1 only in DONE). start outside IDLE ignored.
- Latency: start at edge N -> valid=1 with first vector after edge N; busy=1 from same edge through RUN.
- Handshake: accept = valid & ready. While valid & !ready, A/B/op/last stable. On accept, next vector presented next cycle (back-to-back, no bubble); ready permanently 1 gives one vector per clock.
- Directed mode: op-major: for op = 0..N_OPS-1, for k = 0..3 -> 4*N_OPS vectors. Pairs (A,B): k0 (0,0); k1 (all-ones, 1); k2 (MSB-only, all-ones); k3 (max-positive 0111..1, 1). last on op=N_OPS-1, k=3. len ignored.
- Random mode: 32-bit Galois LFSRs, step: s = (s>>1) ^ (s[0] ? 32'h80200003 : 0). A = LFSR_A[DATA_WIDTH-1:0], B = LFSR_B[DATA_WIDTH-1:0]. Vector i (0-based) uses LFSR state advanced i times; both LFSRs step only on accept. op = i mod N_OPS (wraps to 0 after N_OPS-1). last when i = len-1.
- LFSRs re-seeded on every accepted start; runs are repeatable.
- len = 0 in random mode: IDLE -> DONE directly, no valid, done pulses once, busy 0.
- Vector counter 16-bit, no overflow (max len 65535, directed max 4*N_OPS).
- After run: A/B/op hold last value, valid = 0.
- ready ignored when valid = 0.

Test Plan:
- Reset: rst=1 async mid-cycle during RUN -> valid/busy/done=0, A=B=op=0 immediately; no done pulse after release.
- Directed, ready=1, DATA_WIDTH=32, N_OPS=16: start -> 64 consecutive valid cycles; vector 1 = op 0, A 32'hFFFFFFFF, B 32'h00000001; vector 63 = op 15, A 32'h7FFFFFFF, B 1, last=1; done pulses one cycle later.
- Random, SEED=1, len=3, ready=1: vectors (A,B,op) = (32'h00000001, 32'hFFFFFFFE, 0), (32'h80200003, 32'h7FFFFFFF, 1), third per LFSR step, op 2, last=1; restart reproduces identical sequence.
- Backpressure: random len=5, ready toggled 1,0,0,1,... -> outputs frozen while ready=0; exactly 5 accepts; LFSR steps only on accepts.
- Op wrap: random len=20, N_OPS=16 -> op 0..15 then 0..3; last on 20th.
- Edge cases: len=0 -> done one cycle after start, valid never 1; start pulses during RUN ignored (vector count unchanged).

Source files
------------

// File: rtl/alu_vec_if.sv
// Vector handshake between the ALU stimulus generator and its consumer.
// The master presents {op, A, B, last} under valid. The slave accepts with ready.
interface alu_vec_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
);
    logic                  valid;
    logic                  ready;
    logic                  last;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic [OP_WIDTH-1:0]   op;

    modport master (output valid, A, B, op, last, input ready);
    modport slave  (input valid, A, B, op, last, output ready);
endinterface

// File: rtl/alu_vec_gen.sv
// ALU stimulus generator. It emits a directed corner-value sweep over every opcode,
// or LFSR random operands with a swept opcode for a programmable count.
//
// state | meaning
// IDLE  | waiting for start, outputs hold the previous run's final vector
// RUN   | presenting vectors, advancing on each accept
// DONE  | one-cycle done pulse, then back to IDLE
module alu_vec_gen #(
    parameter int          DATA_WIDTH = 32,
    parameter int          OP_WIDTH   = 4,
    parameter int          N_OPS      = 16,
    parameter logic [31:0] SEED       = 32'h00000001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] len,
    alu_vec_if.master   vec,
    output logic        busy,
    output logic        done
);
    localparam logic [31:0] SEED_A = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [31:0] SEED_B = (~SEED == 32'd0) ? 32'd1 : ~SEED;
    localparam logic [15:0] DIR_LAST = 16'(4 * N_OPS - 1);
    localparam logic [OP_WIDTH-1:0] OP_MAX = OP_WIDTH'(N_OPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic        mode_q;
    logic [15:0] len_q;
    logic [15:0] idx;
    logic [15:0] idx_n;
    logic [31:0] lfsr_a;
    logic [31:0] lfsr_b;
    logic [31:0] lfsr_a_n;
    logic [31:0] lfsr_b_n;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    // Directed corner pairs: (0,0), (all-ones,1), (MSB-only,all-ones), (max-positive,1).
    function automatic logic [DATA_WIDTH-1:0] dir_a(input logic [1:0] k);
        case (k)
            2'd0:    return '0;
            2'd1:    return '1;
            2'd2:    return {1'b1, {(DATA_WIDTH-1){1'b0}}};
            default: return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] dir_b(input logic [1:0] k);
        case (k)
            2'd0:    return '0;
            2'd2:    return '1;
            default: return DATA_WIDTH'(1);
        endcase
    endfunction

    always_comb begin
        idx_n    = idx + 16'd1;
        lfsr_a_n = lfsr_step(lfsr_a);
        lfsr_b_n = lfsr_step(lfsr_b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            vec.valid <= 1'b0;
            vec.last  <= 1'b0;
            vec.A     <= '0;
            vec.B     <= '0;
            vec.op    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mode_q    <= 1'b0;
            len_q     <= '0;
            idx       <= '0;
            lfsr_a    <= SEED_A;
            lfsr_b    <= SEED_B;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        len_q  <= len;
                        idx    <= '0;
                        lfsr_a <= SEED_A;
                        lfsr_b <= SEED_B;
                        if (mode && len == 16'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            vec.valid <= 1'b1;
                            vec.op    <= '0;
                            vec.A     <= mode ? SEED_A[DATA_WIDTH-1:0] : dir_a(2'd0);
                            vec.B     <= mode ? SEED_B[DATA_WIDTH-1:0] : dir_b(2'd0);
                            vec.last  <= mode && (len == 16'd1);
                        end
                    end
                end
                RUN: begin
                    if (vec.valid && vec.ready) begin
                        if (vec.last) begin
                            state     <= DONE;
                            vec.valid <= 1'b0;
                            vec.last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            idx <= idx_n;
                            if (mode_q) begin
                                lfsr_a   <= lfsr_a_n;
                                lfsr_b   <= lfsr_b_n;
                                vec.A    <= lfsr_a_n[DATA_WIDTH-1:0];
                                vec.B    <= lfsr_b_n[DATA_WIDTH-1:0];
                                vec.op   <= (vec.op == OP_MAX) ? '0 : vec.op + OP_WIDTH'(1);
                                vec.last <= (idx_n == len_q - 16'd1);
                            end else begin
                                vec.A    <= dir_a(idx_n[1:0]);
                                vec.B    <= dir_b(idx_n[1:0]);
                                vec.op   <= OP_WIDTH'(idx_n >> 2);
                                vec.last <= (idx_n == DIR_LAST);
                            end
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
